// File: rtl/multicycle_control_fsm_if.sv
// rtl/multicycle_control_fsm_if.sv - opcode/handshake inputs and datapath controls of the multicycle main FSM
interface multicycle_control_fsm_if #(
    parameter int CNT_W = 32
);
    logic [6:0]       op;
    logic             mem_ready;
    logic             PCUpdate;
    logic             Branch;
    logic             RegWrite;
    logic             MemWrite;
    logic             IRWrite;
    logic             AdrSrc;
    logic [1:0]       ResultSrc;
    logic [1:0]       ALUSrcA;
    logic [1:0]       ALUSrcB;
    logic [1:0]       ALUOp;
    logic [1:0]       ImmSrc;
    logic             trap;
    logic             retire;
    logic [CNT_W-1:0] retired_cnt;

    modport master (
        output op, mem_ready,
        input  PCUpdate, Branch, RegWrite, MemWrite, IRWrite, AdrSrc, ResultSrc,
               ALUSrcA, ALUSrcB, ALUOp, ImmSrc, trap, retire, retired_cnt
    );

    modport slave (
        input  op, mem_ready,
        output PCUpdate, Branch, RegWrite, MemWrite, IRWrite, AdrSrc, ResultSrc,
               ALUSrcA, ALUSrcB, ALUOp, ImmSrc, trap, retire, retired_cnt
    );
endinterface

// File: rtl/multicycle_control_fsm.sv
// rtl/multicycle_control_fsm.sv - multicycle RV32I main control FSM with memory stall and retire counter
module multicycle_control_fsm #(
    parameter bit SUPPORT_ITYPE = 1'b1,
    parameter bit SUPPORT_JAL   = 1'b1,
    parameter int CNT_W         = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    multicycle_control_fsm_if.slave bus
);
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    typedef enum logic [3:0] {
        S_RESET, S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
        S_EXECUTER, S_EXECUTEI, S_ALUWB, S_BEQ, S_JAL, S_TRAP
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             pc_update, branch, reg_write, mem_write, ir_write, adr_src;
    logic             trap, retire;
    logic [1:0]       result_src, alu_src_a, alu_src_b, alu_op, imm_src;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_RESET;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      cnt <= '0;
        else if (retire) cnt <= cnt + CNT_W'(1);
    end

    always_comb begin
        imm_src = 2'b00;
        case (bus.op)
            OP_SW:   imm_src = 2'b01;
            OP_BEQ:  imm_src = 2'b10;
            OP_JAL:  imm_src = 2'b11;
            default: imm_src = 2'b00;
        endcase
    end

    always_comb begin
        state_nxt  = state;
        pc_update  = 1'b0;
        branch     = 1'b0;
        reg_write  = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        adr_src    = 1'b0;
        result_src = 2'b00;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        trap       = 1'b0;
        retire     = 1'b0;
        case (state)
            S_RESET: state_nxt = S_FETCH;
            S_FETCH: begin
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                ir_write   = bus.mem_ready;
                pc_update  = bus.mem_ready;
                if (bus.mem_ready) state_nxt = S_DECODE;
            end
            S_DECODE: begin
                // Precompute the branch target from oldPC while the opcode is decoded.
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                case (bus.op)
                    OP_LW, OP_SW: state_nxt = S_MEMADR;
                    OP_R:         state_nxt = S_EXECUTER;
                    OP_I:         state_nxt = SUPPORT_ITYPE ? S_EXECUTEI : S_TRAP;
                    OP_BEQ:       state_nxt = S_BEQ;
                    OP_JAL:       state_nxt = SUPPORT_JAL ? S_JAL : S_TRAP;
                    default:      state_nxt = S_TRAP;
                endcase
            end
            S_MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                state_nxt = (bus.op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                adr_src = 1'b1;
                if (bus.mem_ready) state_nxt = S_MEMWB;
            end
            S_MEMWB: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
                retire     = 1'b1;
                state_nxt  = S_FETCH;
            end
            S_MEMWRITE: begin
                adr_src   = 1'b1;
                mem_write = 1'b1;
                retire    = bus.mem_ready;
                if (bus.mem_ready) state_nxt = S_FETCH;
            end
            S_EXECUTER: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b10;
                state_nxt = S_ALUWB;
            end
            S_EXECUTEI: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                alu_op    = 2'b10;
                state_nxt = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write = 1'b1;
                retire    = 1'b1;
                state_nxt = S_FETCH;
            end
            S_BEQ: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b01;
                branch    = 1'b1;
                retire    = 1'b1;
                state_nxt = S_FETCH;
            end
            S_JAL: begin
                // Jump now; the link write-back (rd = PC+4) retires in ALUWB.
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                pc_update = 1'b1;
                state_nxt = S_ALUWB;
            end
            S_TRAP: trap = 1'b1;
            default: state_nxt = S_RESET;
        endcase
    end

    assign bus.PCUpdate    = pc_update;
    assign bus.Branch      = branch;
    assign bus.RegWrite    = reg_write;
    assign bus.MemWrite    = mem_write;
    assign bus.IRWrite     = ir_write;
    assign bus.AdrSrc      = adr_src;
    assign bus.ResultSrc   = result_src;
    assign bus.ALUSrcA     = alu_src_a;
    assign bus.ALUSrcB     = alu_src_b;
    assign bus.ALUOp       = alu_op;
    assign bus.ImmSrc      = imm_src;
    assign bus.trap        = trap;
    assign bus.retire      = retire;
    assign bus.retired_cnt = cnt;
endmodule

// File: tb/tb_multicycle_control_fsm.sv
// tb/tb_multicycle_control_fsm.sv - scoreboard bench for multicycle_control_fsm
module tb_multicycle_control_fsm;
    localparam int CNT_W = 4;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    multicycle_control_fsm_if #(.CNT_W(CNT_W)) bus ();
    multicycle_control_fsm_if #(.CNT_W(32))    bus2 ();

    multicycle_control_fsm #(.SUPPORT_ITYPE(1'b1), .SUPPORT_JAL(1'b1), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus.slave));
    multicycle_control_fsm #(.SUPPORT_ITYPE(1'b0), .SUPPORT_JAL(1'b1), .CNT_W(32)) dut_noi (
        .clk(clk), .rst_n(rst_n), .bus(bus2.slave));

    logic [17:0] obs1, obs2;
    assign obs1 = {bus.PCUpdate, bus.Branch, bus.RegWrite, bus.MemWrite, bus.IRWrite, bus.AdrSrc,
                   bus.ResultSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ALUOp, bus.ImmSrc, bus.trap, bus.retire};
    assign obs2 = {bus2.PCUpdate, bus2.Branch, bus2.RegWrite, bus2.MemWrite, bus2.IRWrite, bus2.AdrSrc,
                   bus2.ResultSrc, bus2.ALUSrcA, bus2.ALUSrcB, bus2.ALUOp, bus2.ImmSrc, bus2.trap, bus2.retire};

    typedef struct {
        logic [6:0]  op;
        logic        mr;
        logic [17:0] exp;
        bit          first;
        bit          both;
    } entry_t;

    entry_t     sb_q[$];
    int         lat_q[$];
    int         n_checks = 0;
    int         n_pass = 0;
    int         icyc = 0;
    logic [CNT_W-1:0] exp_cnt = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic [17:0] ctl(input logic pcu, br, rw, mw, irw, adr,
                                        input logic [1:0] rs, sa, sb, aop, im,
                                        input logic tr, rt);
        return {pcu, br, rw, mw, irw, adr, rs, sa, sb, aop, im, tr, rt};
    endfunction

    function automatic logic [1:0] imm_of(input logic [6:0] op);
        case (op)
            OP_SW:   return 2'b01;
            OP_BEQ:  return 2'b10;
            OP_JAL:  return 2'b11;
            default: return 2'b00;
        endcase
    endfunction

    task automatic push_e(input logic [6:0] op, input logic mr, input logic [17:0] exp,
                          input bit first, input bit both);
        entry_t e;
        e.op = op; e.mr = mr; e.exp = exp; e.first = first; e.both = both;
        sb_q.push_back(e);
    endtask

    task automatic push_fetch_decode(input logic [6:0] op, input int fw, input bit both);
        logic [1:0] im;
        im = imm_of(op);
        for (int i = 0; i < fw; i++) push_e(op, 1'b0, ctl(0,0,0,0,0,0, 2'd2,2'd0,2'd2,2'd0, im, 0,0), i == 0, both);
        push_e(op, 1'b1, ctl(1,0,0,0,1,0, 2'd2,2'd0,2'd2,2'd0, im, 0,0), fw == 0, both);
        push_e(op, 1'b1, ctl(0,0,0,0,0,0, 2'd0,2'd1,2'd1,2'd0, im, 0,0), 1'b0, both);
    endtask

    task automatic push_instr(input logic [6:0] op, input int fw, input int mw);
        logic [1:0] im;
        int lat;
        im = imm_of(op);
        lat = 0;
        push_fetch_decode(op, fw, 1'b0);
        case (op)
            OP_LW: begin
                push_e(op, 1'b1, ctl(0,0,0,0,0,0, 2'd0,2'd2,2'd1,2'd0, im, 0,0), 0, 0);
                for (int i = 0; i < mw; i++) push_e(op, 1'b0, ctl(0,0,0,0,0,1, 2'd0,2'd0,2'd0,2'd0, im, 0,0), 0, 0);
                push_e(op, 1'b1, ctl(0,0,0,0,0,1, 2'd0,2'd0,2'd0,2'd0, im, 0,0), 0, 0);
                push_e(op, 1'b1, ctl(0,0,1,0,0,0, 2'd1,2'd0,2'd0,2'd0, im, 0,1), 0, 0);
                lat = 5;
            end
            OP_SW: begin
                push_e(op, 1'b1, ctl(0,0,0,0,0,0, 2'd0,2'd2,2'd1,2'd0, im, 0,0), 0, 0);
                for (int i = 0; i < mw; i++) push_e(op, 1'b0, ctl(0,0,0,1,0,1, 2'd0,2'd0,2'd0,2'd0, im, 0,0), 0, 0);
                push_e(op, 1'b1, ctl(0,0,0,1,0,1, 2'd0,2'd0,2'd0,2'd0, im, 0,1), 0, 0);
                lat = 4;
            end
            OP_R, OP_I: begin
                push_e(op, 1'b1, ctl(0,0,0,0,0,0, 2'd0,2'd2,(op == OP_I) ? 2'd1 : 2'd0,2'd2, im, 0,0), 0, 0);
                push_e(op, 1'b1, ctl(0,0,1,0,0,0, 2'd0,2'd0,2'd0,2'd0, im, 0,1), 0, 0);
                lat = 4;
            end
            OP_BEQ: begin
                push_e(op, 1'b1, ctl(0,1,0,0,0,0, 2'd0,2'd2,2'd0,2'd1, im, 0,1), 0, 0);
                lat = 3;
            end
            default: begin
                push_e(op, 1'b1, ctl(1,0,0,0,0,0, 2'd0,2'd1,2'd2,2'd0, im, 0,0), 0, 0);
                push_e(op, 1'b1, ctl(0,0,1,0,0,0, 2'd0,2'd0,2'd0,2'd0, im, 0,1), 0, 0);
                lat = 4;
            end
        endcase
        lat_q.push_back(lat + fw + mw);
    endtask

    task automatic run_q();
        entry_t e;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            bus.op = e.op;
            bus.mem_ready = e.mr;
            bus2.op = OP_I;
            bus2.mem_ready = e.mr;
            if (e.first) icyc = 0;
            @(negedge clk);
            icyc++;
            check("ctrl", 32'(obs1), 32'(e.exp));
            check("cnt", 32'(bus.retired_cnt), 32'(exp_cnt));
            if (e.both) check("ctrl_noi", 32'(obs2), 32'(e.exp));
            if (bus.retire) begin
                check("retire_expected", 32'(lat_q.size() > 0), 32'd1);
                if (lat_q.size() > 0) check("latency", icyc, lat_q.pop_front());
            end
            if (e.exp[0]) exp_cnt++;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.op = 7'd0;
        bus.mem_ready = 1'b0;
        bus2.op = OP_I;
        bus2.mem_ready = 1'b0;
        @(negedge clk);
        check("rst_ctrl", 32'(obs1), 32'd0);
        check("rst_cnt", 32'(bus.retired_cnt), 32'd0);
        check("rst_ctrl_noi", 32'(obs2), 32'd0);
        check("rst_cnt_noi", bus2.retired_cnt, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_cnt = '0;
        lat_q.delete();
        push_e(7'd0, 1'b1, 18'd0, 1'b0, 1'b1);
    endtask

    initial begin
        do_reset();

        // lw zero-wait, then sw with three memory wait cycles
        push_instr(OP_LW, 0, 0);
        run_q();
        check("lw_cnt", 32'(bus.retired_cnt), 32'd1);
        push_instr(OP_SW, 0, 3);
        run_q();
        check("sw_cnt", 32'(bus.retired_cnt), 32'd2);

        // R, I, beq, jal back to back, then stalled fetch + stalled lw
        do_reset();
        push_instr(OP_R, 0, 0);
        push_instr(OP_I, 0, 0);
        push_instr(OP_BEQ, 0, 0);
        push_instr(OP_JAL, 0, 0);
        run_q();
        check("mix_cnt", 32'(bus.retired_cnt), 32'd4);
        push_instr(OP_LW, 2, 1);
        push_instr(OP_SW, 1, 0);
        run_q();
        check("stall_cnt", 32'(bus.retired_cnt), 32'd6);

        // illegal opcode on main DUT, I-type on the SUPPORT_ITYPE=0 DUT
        do_reset();
        push_fetch_decode(7'd0, 0, 1'b1);
        for (int i = 0; i < 12; i++)
            push_e(7'd0, 1'($urandom_range(0, 1)), ctl(0,0,0,0,0,0, 2'd0,2'd0,2'd0,2'd0, 2'd0, 1,0), 1'b0, 1'b1);
        run_q();
        check("trap_hold", 32'(bus.trap), 32'd1);
        check("trap_hold_noi", 32'(bus2.trap), 32'd1);
        check("trap_cnt", 32'(bus.retired_cnt), 32'd0);

        // 4-bit counter wraps after 16 retires
        do_reset();
        for (int i = 0; i < 17; i++) push_instr(OP_R, 0, 0);
        run_q();
        check("wrap_cnt", 32'(bus.retired_cnt), 32'd1);

        // reset asserted while lw is stalled in MEMREAD
        push_fetch_decode(OP_LW, 0, 1'b0);
        push_e(OP_LW, 1'b1, ctl(0,0,0,0,0,0, 2'd0,2'd2,2'd1,2'd0, 2'd0, 0,0), 0, 0);
        push_e(OP_LW, 1'b0, ctl(0,0,0,0,0,1, 2'd0,2'd0,2'd0,2'd0, 2'd0, 0,0), 0, 0);
        push_e(OP_LW, 1'b0, ctl(0,0,0,0,0,1, 2'd0,2'd0,2'd0,2'd0, 2'd0, 0,0), 0, 0);
        run_q();
        bus.mem_ready = 1'b0;
        @(negedge clk);
        check("memread_hold", 32'(obs1), 32'(ctl(0,0,0,0,0,1, 2'd0,2'd0,2'd0,2'd0, 2'd0, 0,0)));
        check("pre_rst_cnt", 32'(bus.retired_cnt), 32'd1);
        rst_n = 1'b0;
        #1;
        check("midrst_ctrl", 32'(obs1), 32'd0);
        check("midrst_cnt", 32'(bus.retired_cnt), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_cnt = '0;
        push_e(OP_R, 1'b1, 18'd0, 1'b0, 1'b0);
        push_instr(OP_R, 0, 0);
        run_q();
        check("post_rst_cnt", 32'(bus.retired_cnt), 32'd1);
        check("lat_q_drained", lat_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
